// File: rtl/ps2_key_decoder.sv
// rtl/ps2_key_decoder.sv - PS/2 Set-2 scan-code prefix decoder with show-ahead event FIFO
//
// Purpose: turns raw scan-code bytes into make/break key events. The E0
//   (extended) and F0 (break) prefixes are stripped. Controller responses
//   (00 AA EE FA FC FE FF) are discarded. Events go into a show-ahead FIFO
//   that uses a valid/ready handshake.
// Optional feature: define PS2_TYPEMATIC_FILTER_EN to suppress auto-repeat makes.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   byte_in         scan-code byte
//   byte_valid      one-cycle strobe qualifying byte_in
//   evt_ready       consumer takes the head event
//   evt_valid       FIFO holds at least one event
//   evt_code        head event key code, prefixes removed
//   evt_ext         head event was E0-prefixed
//   evt_break       head event is a key release
//   fifo_count      number of queued events
//   overflow        sticky flag: an event was dropped on a full FIFO
module ps2_key_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int ADDR_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              evt_ready,
  output logic              evt_valid,
  output logic [7:0]        evt_code,
  output logic              evt_ext,
  output logic              evt_break,
  output logic [ADDR_W:0]   fifo_count,
  output logic              overflow
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXT    = 2'd1;
  localparam logic [1:0] ST_BRK    = 2'd2;
  localparam logic [1:0] ST_EXTBRK = 2'd3;

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);

  logic [1:0] state, state_nx;
  logic       is_discard;
  logic       dec_push, dec_ext, dec_brk;
  logic       suppress;

  always_comb begin
    is_discard = 1'b0;
    case (byte_in)
      8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: is_discard = 1'b1;
      default: is_discard = 1'b0;
    endcase
  end

  // The prefix FSM moves only when byte_valid is high. A code byte always returns it to IDLE.
  always_comb begin
    state_nx = state;
    dec_push = 1'b0;
    dec_ext  = 1'b0;
    dec_brk  = 1'b0;
    if (byte_valid) begin
      if (is_discard) begin
        state_nx = ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (byte_in == 8'hE0)      state_nx = ST_EXT;
            else if (byte_in == 8'hF0) state_nx = ST_BRK;
            else begin
              state_nx = ST_IDLE;
              dec_push = 1'b1;
            end
          end
          ST_EXT: begin
            if (byte_in == 8'hF0)      state_nx = ST_EXTBRK;
            else if (byte_in == 8'hE0) state_nx = ST_EXT;
            else begin
              state_nx = ST_IDLE;
              dec_push = 1'b1;
              dec_ext  = 1'b1;
            end
          end
          ST_BRK: begin
            // E0 after F0 is a protocol error. The break is dropped and the extension is kept.
            if (byte_in == 8'hE0)      state_nx = ST_EXT;
            else if (byte_in == 8'hF0) state_nx = ST_BRK;
            else begin
              state_nx = ST_IDLE;
              dec_push = 1'b1;
              dec_brk  = 1'b1;
            end
          end
          default: begin
            if (byte_in == 8'hE0 || byte_in == 8'hF0) state_nx = ST_IDLE;
            else begin
              state_nx = ST_IDLE;
              dec_push = 1'b1;
              dec_ext  = 1'b1;
              dec_brk  = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  // The record holds the most recent make. A repeat of it is dropped until that key is released.
  logic       rec_valid;
  logic [7:0] rec_code;
  logic       rec_ext;
  logic       same_key;

  assign same_key = rec_valid && (rec_code == byte_in) && (rec_ext == dec_ext);
  assign suppress = dec_push && !dec_brk && same_key;

  always_ff @(posedge clk) begin
    if (rst) begin
      rec_valid <= 1'b0;
      rec_code  <= 8'h00;
      rec_ext   <= 1'b0;
    end else if (dec_push) begin
      if (!dec_brk) begin
        rec_valid <= 1'b1;
        rec_code  <= byte_in;
        rec_ext   <= dec_ext;
      end else if (same_key) begin
        rec_valid <= 1'b0;
      end
    end
  end
`else
  assign suppress = 1'b0;
`endif

  // A one-stage register between the decoder and the FIFO. Because of it, evt_valid rises one edge after the strobe edge.
  logic       push_q;
  logic [9:0] push_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_q      <= 1'b0;
      push_data_q <= 10'd0;
    end else begin
      push_q      <= dec_push && !suppress;
      push_data_q <= {dec_ext, dec_brk, byte_in};
    end
  end

  // The FIFO stores each entry as {ext, brk, code}.
  logic [9:0]        mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count;
  logic [9:0]        last_entry;
  logic [9:0]        head, out_entry;
  logic              full, do_pop, do_push;

  assign head      = mem[rd_ptr];
  assign evt_valid = (count != '0);
  assign full      = (count == FULL_CNT);
  assign do_pop    = evt_valid && evt_ready;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign do_push   = push_q && (!full || do_pop);

  // When the FIFO is empty, the outputs keep showing the last popped entry.
  assign out_entry  = evt_valid ? head : last_entry;
  assign evt_ext    = out_entry[9];
  assign evt_break  = out_entry[8];
  assign evt_code   = out_entry[7:0];
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_entry <= 10'd0;
      overflow   <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop) begin
        rd_ptr     <= rd_ptr + PTR_ONE;
        last_entry <= head;
      end
      if (do_push && !do_pop)      count <= count + CNT_ONE;
      else if (do_pop && !do_push) count <= count - CNT_ONE;
      if (push_q && full && !do_pop) overflow <= 1'b1;
    end
  end

endmodule
